// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - round-robin burst arbiter sharing one registered downstream stream
module stream_rr_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int BEATS = 4
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic [N-1:0]       iValid_AM,
    output logic [N-1:0]       oReady_AM,
    input  logic [N*WIDTH-1:0] iData_AM,
    output logic               oValid_BM,
    input  logic               iReady_BM,
    output logic [WIDTH-1:0]   oData_BM,
    output logic [N-1:0]       oGrant,
    output logic               oBusy
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(BEATS + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [PW-1:0] LAST_IDX  = PW'(N - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    ptr, ptr_nxt, gidx, gidx_nxt, pick;
    logic             pick_vld;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [N-1:0]     grant_nxt;
    logic             load, up_acc;
    logic [WIDTH-1:0] up_data;

    assign load      = !oValid_BM || iReady_BM;
    assign oReady_AM = (state == GRANT && load) ? oGrant : '0;
    assign up_acc    = |(iValid_AM & oReady_AM);
    assign oBusy     = (state == GRANT);

    always_comb begin
        up_data = '0;
        for (int k = 0; k < N; k++) begin
            if (gidx == PW'(k)) up_data = iData_AM[k*WIDTH +: WIDTH];
        end
    end

    // First requesting index at or after the pointer; wrap is explicit so N need not be 2^k
    always_comb begin
        int idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!pick_vld && iValid_AM[idx]) begin
                pick     = PW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gidx_nxt  = gidx;
        cnt_nxt   = cnt;
        grant_nxt = oGrant;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = GRANT;
                    gidx_nxt  = pick;
                    grant_nxt = {{(N-1){1'b0}}, 1'b1} << pick;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                // The grant is held until the full burst has been taken, even if valid drops
                if (up_acc) begin
                    if (cnt == LAST_BEAT) begin
                        state_nxt = IDLE;
                        ptr_nxt   = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
                        grant_nxt = '0;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state  <= IDLE;
            ptr    <= '0;
            gidx   <= '0;
            cnt    <= '0;
            oGrant <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            gidx   <= gidx_nxt;
            cnt    <= cnt_nxt;
            oGrant <= grant_nxt;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oValid_BM <= 1'b0;
            oData_BM  <= '0;
        end else if (up_acc) begin
            oValid_BM <= 1'b1;
            oData_BM  <= up_data;
        end else if (iReady_BM) begin
            oValid_BM <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - self-checking bench for stream_rr_arbiter
module tb_stream_rr_arbiter;
    localparam int N = 4, W = 8, BEATS = 4, MAXC = 4096;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0] valid, ready, grant;
    logic [N*W-1:0] data;
    logic ov, ir, busy;
    logic [W-1:0] od;

    logic [2:0] v3, r3, g3;
    logic [23:0] d3;
    logic ov3, b3, ir3;
    logic [7:0] od3;

    logic [N-1:0]   h_v [MAXC];
    logic [N-1:0]   h_g [MAXC];
    logic [N-1:0]   h_r [MAXC];
    logic           h_ov[MAXC];
    logic           h_ir[MAXC];
    logic [W-1:0]   h_od[MAXC];
    logic [N*W-1:0] h_din[MAXC];

    int n_chk, n_fail, cyc;
    int seq[N];
    logic [W-1:0] base[N];

    always #5 clk = ~clk;

    stream_rr_arbiter #(.N(N), .WIDTH(W), .BEATS(BEATS)) dut (
        .iCLK(clk), .iRST_N(rst_n),
        .iValid_AM(valid), .oReady_AM(ready), .iData_AM(data),
        .oValid_BM(ov), .iReady_BM(ir), .oData_BM(od),
        .oGrant(grant), .oBusy(busy)
    );

    stream_rr_arbiter #(.N(3), .WIDTH(8), .BEATS(4)) dut3 (
        .iCLK(clk), .iRST_N(rst_n),
        .iValid_AM(v3), .oReady_AM(r3), .iData_AM(d3),
        .oValid_BM(ov3), .iReady_BM(ir3), .oData_BM(od3),
        .oGrant(g3), .oBusy(b3)
    );

    task automatic set_data();
        for (int k = 0; k < N; k++) data[k*W +: W] = base[k] + W'(seq[k]);
    endtask

    // Called at a falling edge: records this cycle's handshake view, then advances one cycle
    task automatic tick();
        #1;
        if (cyc >= MAXC) begin
            n_fail++;
            $display("FAIL history_overflow: cycle %0d, limit %0d", cyc, MAXC);
            $fatal(1, "history overflow");
        end
        h_v[cyc] = valid; h_g[cyc] = grant; h_r[cyc] = ready;
        h_ov[cyc] = ov; h_ir[cyc] = ir; h_od[cyc] = od; h_din[cyc] = data;
        for (int k = 0; k < N; k++) if (valid[k] && ready[k]) seq[k]++;
        cyc++;
        @(negedge clk);
        set_data();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; valid = '0; v3 = '0; ir = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) seq[k] = 0;
        set_data();
    endtask

    task automatic test_reset();
        int t;
        rst_n = 1'b0; valid = '1; ir = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (grant !== '0) begin n_fail++; $display("FAIL rst_grant: got %b expected 0", grant); end
        n_chk++; if (ready !== '0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", ready); end
        n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", ov); end
        n_chk++; if (od !== '0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", od); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) seq[k] = 0;
        set_data();
        valid = 4'b0010; t = 0;
        while (!(seq[1] >= BEATS && grant === '0) && t < 20) begin tick(); t++; end
        n_chk++; if (t >= 20) begin n_fail++; $display("FAIL rst_setup_burst: timed out after %0d cycles, expected completion", t); end
        valid = 4'b0100; t = 0;
        while (seq[2] < 2 && t < 20) begin tick(); t++; end
        n_chk++; if (seq[2] !== 2) begin n_fail++; $display("FAIL rst_mid_burst: got %0d beats expected 2", seq[2]); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({ov, od, grant, busy, ready} !== '0)
            begin n_fail++; $display("FAIL rst_async: got v=%b d=%h g=%b b=%b r=%b expected all 0", ov, od, grant, busy, ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) seq[k] = 0;
        set_data();
        valid = '1;
        tick();
        n_chk++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rst_restart_grant: got %b expected 0001", grant); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_restart_busy: got %b expected 1", busy); end
    endtask

    task automatic test_single();
        int t0, t, c;
        logic [W-1:0] e;
        do_reset();
        base[2] = 8'h10; set_data();
        valid = 4'b0100; ir = 1'b1; t0 = cyc; t = 0;
        while (seq[2] < 8 && t < 40) begin tick(); t++; end
        valid = '0;
        repeat (4) tick();
        base[2] = 8'h80;
        n_chk++; if (seq[2] !== 8) begin n_fail++; $display("FAIL single_count: got %0d expected 8", seq[2]); end
        n_chk++; if (h_g[t0+1] !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b expected 0100", h_g[t0+1]); end
        n_chk++; if (h_ov[t0+1] !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b expected 0", h_ov[t0+1]); end
        n_chk++; if (h_ov[t0+6] !== 1'b0 || h_g[t0+5] !== '0)
            begin n_fail++; $display("FAIL single_gap: got v=%b g=%b expected v=0 g=0000", h_ov[t0+6], h_g[t0+5]); end
        for (int i = 0; i < 8; i++) begin
            c = t0 + 2 + i + ((i >= 4) ? 1 : 0);
            e = 8'h10 + W'(i);
            n_chk++; if (h_ov[c] !== 1'b1 || h_od[c] !== e)
                begin n_fail++; $display("FAIL single_beat%0d: got v=%b d=%h expected v=1 d=%h", i, h_ov[c], h_od[c], e); end
        end
    endtask

    task automatic test_all_four();
        int t0, t, total, j;
        int cnt[N];
        int order[5] = '{0, 1, 2, 3, 0};
        logic [W-1:0] q[$];
        logic [W-1:0] e, dv;
        do_reset();
        valid = '1; t0 = cyc; t = 0; total = 0;
        while (total < 20 && t < 300) begin
            ir = ($urandom_range(0, 3) != 0);
            tick(); t++;
            total = seq[0] + seq[1] + seq[2] + seq[3];
        end
        valid = '0; ir = 1'b1;
        repeat (6) tick();
        n_chk++; if (total !== 20) begin n_fail++; $display("FAIL all4_accepts: got %0d expected 20", total); end
        j = 0;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        for (int c = t0; c < cyc; c++) begin
            if (h_ov[c] && h_ir[c]) begin
                n_chk++;
                if (q.size() == 0) begin n_fail++; $display("FAIL all4_down_extra: got %h expected no beat", h_od[c]); end
                else begin
                    dv = q.pop_front();
                    if (h_od[c] !== dv) begin n_fail++; $display("FAIL all4_down_data: got %h expected %h", h_od[c], dv); end
                end
            end
            for (int k = 0; k < N; k++) begin
                if (h_v[c][k] && h_r[c][k]) begin
                    e = base[k] + W'(cnt[k]);
                    n_chk++;
                    if (j >= 20 || k != order[j/BEATS] || h_din[c][k*W +: W] !== e)
                        begin n_fail++; $display("FAIL all4_burst beat %0d: got src %0d data %h expected src %0d data %h", j, k, h_din[c][k*W +: W], order[(j < 20) ? j/BEATS : 0], e); end
                    q.push_back(h_din[c][k*W +: W]);
                    cnt[k]++; j++;
                end
            end
        end
        n_chk++; if (q.size() != 0) begin n_fail++; $display("FAIL all4_drain: got %0d undelivered expected 0", q.size()); end
    endtask

    task automatic test_backpressure();
        int t, t0, n;
        logic [W-1:0] e;
        do_reset();
        valid = 4'b0001; t0 = cyc; t = 0;
        while (seq[0] < 4 && t < 40) begin ir = (t % 4 == 0) || (t % 4 == 3); tick(); t++; end
        valid = '0;
        for (int i = 0; i < 6; i++) begin ir = (t % 4 == 0) || (t % 4 == 3); tick(); t++; end
        n = 0;
        for (int c = t0; c < cyc - 1; c++) begin
            if (h_ov[c] && !h_ir[c]) begin
                n_chk++; if (h_r[c] !== '0) begin n_fail++; $display("FAIL bp_ready: got %b expected 0000", h_r[c]); end
                n_chk++; if (h_ov[c+1] !== 1'b1 || h_od[c+1] !== h_od[c])
                    begin n_fail++; $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=%h", h_ov[c+1], h_od[c+1], h_od[c]); end
            end
            if (h_ov[c] && h_ir[c]) begin
                e = base[0] + W'(n);
                n_chk++; if (h_od[c] !== e) begin n_fail++; $display("FAIL bp_data: got %h expected %h", h_od[c], e); end
                n++;
            end
        end
        n_chk++; if (n !== 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", n); end
    endtask

    task automatic test_starvation();
        int t, t0, n;
        logic [W-1:0] e;
        do_reset();
        valid = '1; ir = 1'b1; t0 = cyc; t = 0;
        while (seq[0] < 2 && t < 20) begin tick(); t++; end
        n_chk++; if (seq[0] !== 2) begin n_fail++; $display("FAIL starve_setup: got %0d expected 2", seq[0]); end
        valid[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++; if (h_g[cyc-1] !== 4'b0001) begin n_fail++; $display("FAIL starve_hold: got %b expected 0001", h_g[cyc-1]); end
            n_chk++; if ((h_r[cyc-1] & 4'b1110) !== 4'b0000) begin n_fail++; $display("FAIL starve_others: got %b expected x000", h_r[cyc-1]); end
        end
        valid[0] = 1'b1; t = 0;
        while (seq[0] < 4 && t < 20) begin tick(); t++; end
        n_chk++; if (seq[1] + seq[2] + seq[3] !== 0) begin n_fail++; $display("FAIL starve_leak: got %0d expected 0", seq[1] + seq[2] + seq[3]); end
        n_chk++; if (grant !== '0) begin n_fail++; $display("FAIL starve_release: got %b expected 0000", grant); end
        tick();
        n_chk++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL starve_next: got %b expected 0010", grant); end
        valid = '0;
        repeat (4) tick();
        n = 0;
        for (int c = t0; c < cyc; c++) begin
            if (h_ov[c] && h_ir[c]) begin
                e = base[0] + W'(n);
                n_chk++; if (h_od[c] !== e) begin n_fail++; $display("FAIL starve_data: got %h expected %h", h_od[c], e); end
                n++;
            end
        end
        n_chk++; if (n !== 4) begin n_fail++; $display("FAIL starve_count: got %0d expected 4", n); end
    endtask

    task automatic test_nonpow2();
        int t, n;
        logic [2:0] prev;
        logic [2:0] got[4];
        logic [2:0] exp_g[4] = '{3'b100, 3'b001, 3'b100, 3'b001};
        do_reset();
        ir3 = 1'b1; v3 = 3'b010; t = 0;
        while (g3 !== 3'b010 && t < 10) begin @(negedge clk); t++; end
        while (g3 !== 3'b000 && t < 30) begin @(negedge clk); t++; end
        n_chk++; if (t >= 30) begin n_fail++; $display("FAIL np2_setup: timed out after %0d cycles, expected release", t); end
        v3 = 3'b101; n = 0; prev = 3'b000;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (g3 != 3'b000 && prev == 3'b000) begin got[n] = g3; n++; end
            prev = g3;
            n_chk++; if (r3[1] !== 1'b0) begin n_fail++; $display("FAIL np2_ready1: got %b expected 0", r3[1]); end
            n_chk++; if (b3 !== (g3 != 3'b000)) begin n_fail++; $display("FAIL np2_busy: got %b expected %b", b3, g3 != 3'b000); end
            if (ov3) begin
                n_chk++; if (od3 !== 8'h01 && od3 !== 8'h03) begin n_fail++; $display("FAIL np2_data: got %h expected 01 or 03", od3); end
            end
        end
        n_chk++; if (n !== 4) begin n_fail++; $display("FAIL np2_grants: got %0d expected 4", n); end
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                n_chk++; if (got[i] !== exp_g[i]) begin n_fail++; $display("FAIL np2_order%0d: got %b expected %b", i, got[i], exp_g[i]); end
            end
        end
        v3 = '0;
    endtask

    task automatic test_random();
        int t0, owner, pnt, cnt, pick;
        logic [N-1:0] exp_g, exp_r;
        logic [W-1:0] q[$];
        logic [W-1:0] dv;
        do_reset();
        t0 = cyc;
        for (int t = 0; t < 400; t++) begin
            valid = N'($urandom_range(0, (1 << N) - 1));
            ir = ($urandom_range(0, 3) != 0);
            tick();
        end
        valid = '0; ir = 1'b1;
        repeat (8) tick();
        owner = -1; pnt = 0; cnt = 0;
        for (int c = t0; c < cyc; c++) begin
            exp_g = (owner < 0) ? '0 : N'(1 << owner);
            exp_r = (owner >= 0 && (!h_ov[c] || h_ir[c])) ? exp_g : '0;
            n_chk++; if (h_g[c] !== exp_g) begin n_fail++; $display("FAIL rand_grant @%0d: got %b expected %b", c, h_g[c], exp_g); end
            n_chk++; if (h_r[c] !== exp_r) begin n_fail++; $display("FAIL rand_ready @%0d: got %b expected %b", c, h_r[c], exp_r); end
            if (c > t0 && h_ov[c-1] && !h_ir[c-1]) begin
                n_chk++; if (h_ov[c] !== 1'b1 || h_od[c] !== h_od[c-1])
                    begin n_fail++; $display("FAIL rand_stall @%0d: got v=%b d=%h expected v=1 d=%h", c, h_ov[c], h_od[c], h_od[c-1]); end
            end
            if (h_ov[c] && h_ir[c]) begin
                n_chk++;
                if (q.size() == 0) begin n_fail++; $display("FAIL rand_down_extra @%0d: got %h expected no beat", c, h_od[c]); end
                else begin
                    dv = q.pop_front();
                    if (h_od[c] !== dv) begin n_fail++; $display("FAIL rand_down_data @%0d: got %h expected %h", c, h_od[c], dv); end
                end
            end
            if (owner < 0) begin
                pick = -1;
                for (int i = 0; i < N; i++) if (pick < 0 && h_v[c][(pnt + i) % N]) pick = (pnt + i) % N;
                if (pick >= 0) begin owner = pick; cnt = 0; end
            end else if (h_v[c][owner] && exp_r[owner]) begin
                q.push_back(h_din[c][owner*W +: W]);
                cnt++;
                if (cnt == BEATS) begin pnt = (owner + 1) % N; owner = -1; end
            end
        end
        n_chk++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d undelivered expected 0", q.size()); end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        valid = '0; ir = 1'b1; v3 = '0; ir3 = 1'b1; d3 = 24'h030201; data = '0;
        for (int k = 0; k < N; k++) begin base[k] = W'(k * 64); seq[k] = 0; end
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_starvation();
        test_nonpow2();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one downstream valid/ready stream between N upstream requesters, e.g. several stream sources feeding one consumer.
- Grants use round-robin and are locked for a fixed burst of BEATS transfers. This keeps each requester's beats contiguous downstream.
- Output is registered, with one stage of buffering on the downstream side.

Parameters:
- N, 4, number of requesters (2..16).
- WIDTH, 8, data width per beat.
- BEATS, 4, beats per grant (1..256).

Ports:
- iCLK  input  1  clock; all state changes on the rising edge.
- iRST_N  input  1  reset, asynchronous assert, active-low.
- iValid_AM  input  N  per-requester valid; bit k belongs to requester k.
- oReady_AM  output  N  per-requester ready.
- iData_AM  input  N*WIDTH  requester k data occupies bits [k*WIDTH +: WIDTH].
- oValid_BM  output  1  downstream valid.
- iReady_BM  input  1  downstream ready.
- oData_BM  output  WIDTH  downstream data.
- oGrant  output  N  one-hot owner of the current burst; 0 when IDLE.
- oBusy  output  1  high while in GRANT.

Behaviour:
- Reset (iRST_N low, asynchronous) forces:
  - state=IDLE, rr pointer=0, beat count=0.
  - oValid_BM=0, oData_BM=0, oGrant=0, oBusy=0, oReady_AM=0.
- Reset deasserted mid-burst: the partial burst is abandoned. Nothing is replayed.
- Transfer rule:
  - An upstream beat moves when iValid_AM[k] && oReady_AM[k].
  - A downstream beat moves when oValid_BM && iReady_BM.
- Output register:
  - Can load when (!oValid_BM || iReady_BM); call this "load".
  - oReady_AM[g] = state==GRANT && load, for granted index g only. All other oReady_AM bits are 0.
  - On an upstream accept: oData_BM <= iData_AM[g] and oValid_BM <= 1 on the next edge. Latency is exactly 1 cycle.
  - On a downstream accept with no upstream accept: oValid_BM <= 0.
  - oData_BM holds its value while oValid_BM && !iReady_BM.
- State machine:
  - IDLE:
    - If any iValid_AM bit is set, choose g = the first set index starting at the rr pointer, wrapping modulo N.
    - Register oGrant = 1<<g, go to GRANT, clear the beat count.
    - With no requests, stay in IDLE; the pointer is unchanged.
  - GRANT:
    - Count upstream accepts from g.
    - On the accept that brings the count to BEATS:
      - Go to IDLE next edge.
      - Pointer <= (g+1) mod N.
      - oGrant <= 0.
    - A requester deasserting valid mid-burst does not release the grant; the arbiter waits for it.
  - Grant-to-grant gap: one IDLE cycle between bursts, so at most BEATS beats per BEATS+1 cycles from one requester.
  - A draining output beat may overlap the IDLE cycle.
- Fairness: a requester waits at most N-1 bursts.
- Simultaneous load and unload of the output register is allowed. Full throughput applies inside a burst when iReady_BM is held high.
- Widths:
  - Beat counter is $clog2(BEATS+1) bits.
  - Pointer is $clog2(N) bits.
  - Pointer wrap is explicit (N need not be a power of 2).
- oData_BM never changes while oValid_BM && !iReady_BM. oValid_BM never drops without a downstream accept.

Test Plan:
- Reset: drive iRST_N=0 asynchronously mid-burst (3rd beat of 4) -> all outputs 0 immediately. After release, the next grant starts from requester 0.
- Single requester, N=4, BEATS=4, iValid_AM=4'b0100, data 0x10..0x17, iReady_BM=1 ->
  - oGrant=4'b0100.
  - Output sequence 0x10,0x11,0x12,0x13, then one idle cycle, then 0x14..0x17.
  - First oValid_BM occurs 2 cycles after iValid_AM rises.
- All four requesting continuously -> bursts ordered 0,1,2,3,0; each burst is exactly 4 contiguous beats tagged with the correct source data.
- Backpressure: iReady_BM toggles 1,0,0,1 during a burst ->
  - No beat is lost or duplicated.
  - oData_BM is stable while stalled.
  - oReady_AM[g] is low whenever the output is full and not draining.
- Mid-burst starvation: the granted requester drops valid for 5 cycles after beat 2 -> grant is held, other requesters see oReady_AM=0, burst completes with beats 3 and 4.
- Non-power-of-2: N=3, requesters 0 and 2 active, pointer starting at 2 -> grant order 2,0,2,0 with correct wrap.
